instr_router: RTL and testbench

- Parametrised successor to the single-shot self/left/right instruction steering block.
- Accepts a stream of instructions, each tagged with a destination index, over a valid/ready handshake.
- Buffers each instruction in a per-destination FIFO and presents it on that channel's valid/ready output.
- Sits between the instruction source and the local node and neighbour links; destinations with bad indices are dropped and counted.

---
 rtl/instr_router.sv | 135 +++++++++++++
 tb/tb_instr_router.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : instr_router
// Purpose  : Steers a stream of destination-tagged instructions into
//            per-channel FIFOs. Each FIFO drives its own valid/ready output
//            channel. Index 0 = self, 1 = right, 2 = left. Words whose
//            destination index is out of range are dropped. Dropped words
//            are reported by a one-cycle pulse and a saturating counter.
// Ports    : clk         - system clock, rising edge
//            reset       - synchronous active-high reset
//            in_valid    - source presents an instruction
//            in_ready    - router accepts the presented instruction
//            in_dest     - destination channel index
//            in_instr    - instruction word
//            out_valid   - per channel: head entry present
//            out_ready   - per channel: consumer takes the head entry
//            out_instr   - per channel head entry, slice k at [k*WIDTH +: WIDTH]
//            drop_err    - registered pulse, the cycle after a drop
//            drop_count  - saturating count of dropped instructions
// Revision : 1.0 - initial parametrised release
// ============================================================================
module instr_router #(
  parameter int WIDTH     = 32,
  parameter int NUM_PORTS = 3,
  parameter int DEST_W    = 2,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DEST_W-1:0]          in_dest,
  input  logic [WIDTH-1:0]           in_instr,
  output logic [NUM_PORTS-1:0]       out_valid,
  input  logic [NUM_PORTS-1:0]       out_ready,
  output logic [NUM_PORTS*WIDTH-1:0] out_instr,
  output logic                       drop_err,
  output logic [CNT_W-1:0]           drop_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [DEST_W:0]  c_NUM_PORTS = (DEST_W + 1)'(NUM_PORTS);
  localparam logic [OCC_W-1:0] c_DEPTH     = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

  logic                 w_dest_bad;
  logic                 w_sel_full;
  logic                 w_accept;
  logic                 w_drop;
  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_dest_hit;

  logic                 r_drop_err;
  logic [CNT_W-1:0]     r_drop_count;

  // Zero-extend the index so the comparison also works when
  // 2^DEST_W == NUM_PORTS.
  assign w_dest_bad = ({1'b0, in_dest} >= c_NUM_PORTS);

  // w_dest_hit is one-hot or all-zero, so this selects the target's full flag.
  assign w_sel_full = |(w_full & w_dest_hit);

  // Only registered occupancy is used here. A pop in the same cycle does not
  // open a slot for a push.
  assign in_ready = !reset && (w_dest_bad || !w_sel_full);
  assign w_accept = in_valid && in_ready;
  assign w_drop   = w_accept && w_dest_bad;

  generate
    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_chan
      localparam logic [DEST_W-1:0] c_IDX = DEST_W'(k);

      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [PTR_W-1:0] r_wptr;
      logic [PTR_W-1:0] r_rptr;
      logic [OCC_W-1:0] r_occ;
      logic             w_push;
      logic             w_pop;
      logic             w_empty;

      assign w_dest_hit[k] = (in_dest == c_IDX);
      assign w_empty       = (r_occ == '0);
      assign w_full[k]     = (r_occ == c_DEPTH);
      // An in-range hit can never also be a drop, so no extra qualification.
      assign w_push        = w_accept && w_dest_hit[k];
      assign w_pop         = !w_empty && out_ready[k];

      always_ff @(posedge clk) begin
        if (reset) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_occ  <= '0;
        end else begin
          if (w_push) r_wptr <= r_wptr + PTR_W'(1);
          if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
          case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
          endcase
        end
      end

      // Storage is not reset. Stale contents are never visible because the
      // output slice is masked while the channel is empty.
      always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= in_instr;
      end

      assign out_valid[k]                 = !w_empty;
      assign out_instr[k*WIDTH +: WIDTH]  = w_empty ? '0 : r_mem[r_rptr];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_err   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_drop_err <= w_drop;
      if (w_drop && (r_drop_count != c_CNT_MAX)) begin
        r_drop_count <= r_drop_count + CNT_W'(1);
      end
    end
  end

  assign drop_err   = r_drop_err;
  assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_router
// Purpose  : Self-checking bench for instr_router. A per-channel queue model
//            predicts in_ready, the channel outputs and the drop status.
//            Stimulus is a set of directed scenarios followed by random
//            traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_router;

  localparam int WIDTH     = 32;
  localparam int NUM_PORTS = 3;
  localparam int DEST_W    = 2;
  localparam int DEPTH     = 4;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = 255;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [DEST_W-1:0]          in_dest = '0;
  logic [WIDTH-1:0]           in_instr = '0;
  logic [NUM_PORTS-1:0]       out_valid;
  logic [NUM_PORTS-1:0]       out_ready = '0;
  logic [NUM_PORTS*WIDTH-1:0] out_instr;
  logic                       drop_err;
  logic [CNT_W-1:0]           drop_count;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: one queue per channel, plus the drop status.
  logic [WIDTH-1:0] mq [NUM_PORTS][$];
  bit               m_err;
  int               m_cnt;

  instr_router #(
    .WIDTH(WIDTH), .NUM_PORTS(NUM_PORTS), .DEST_W(DEST_W),
    .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .drop_err  (drop_err),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NUM_PORTS; k++) begin
      chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(mq[k].size() != 0));
      chk($sformatf("out_instr[%0d]", k), 64'(out_instr[k*WIDTH +: WIDTH]),
          (mq[k].size() != 0) ? 64'(mq[k][0]) : 64'd0);
    end
    chk("drop_err", 64'(drop_err), 64'(m_err));
    chk("drop_count", 64'(drop_count), 64'(m_cnt));
  endtask

  // One clock cycle: drive inputs, check in_ready, clock, update the model
  // and check the registered outputs.
  task automatic step(input bit rs, input bit v, input int d,
                      input logic [WIDTH-1:0] w, input logic [NUM_PORTS-1:0] rdy);
    bit exp_rdy;
    bit acc;
    reset     = rs;
    in_valid  = v;
    in_dest   = DEST_W'(d);
    in_instr  = w;
    out_ready = rdy;
    #1;
    if (rs)                  exp_rdy = 1'b0;
    else if (d >= NUM_PORTS) exp_rdy = 1'b1;
    else                     exp_rdy = (mq[d].size() < DEPTH);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    if (rs) begin
      for (int k = 0; k < NUM_PORTS; k++) mq[k].delete();
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++)
        if (mq[k].size() != 0 && rdy[k]) void'(mq[k].pop_front());
      m_err = acc && (d >= NUM_PORTS);
      if (acc && d < NUM_PORTS) mq[d].push_back(w);
      if (m_err && m_cnt < CNT_MAX) m_cnt++;
    end
    check_outputs();
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH; i++) step(0, 0, 0, '0, '1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_err = 1'b0;
    m_cnt = 0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    chk("reset_valid", 64'(out_valid), 64'd0);

    // Single push to self, visible one cycle later
    step(0, 1, 0, 32'hDEADBEEF, '0);
    chk("tp1_valid", 64'(out_valid), 64'b001);
    chk("tp1_slice0", 64'(out_instr[0 +: WIDTH]), 64'hDEADBEEF);
    step(0, 0, 0, '0, '0);
    drain();

    // Fill channel 2, check backpressure, then pop in order
    for (int i = 1; i <= 4; i++) step(0, 1, 2, WIDTH'(i), '0);
    step(0, 1, 2, 32'h5, '0);
    step(0, 0, 1, '0, '0);
    for (int i = 1; i <= 4; i++) begin
      chk("tp2_head", 64'(out_instr[2*WIDTH +: WIDTH]), 64'(i));
      step(0, 0, 0, '0, 3'b100);
    end
    chk("tp2_empty", 64'(out_valid[2]), 64'd0);

    // Drops, then saturation
    for (int i = 0; i < 3; i++) step(0, 1, 3, 32'h33, '0);
    chk("tp3_count", 64'(drop_count), 64'd3);
    step(0, 0, 0, '0, '0);
    for (int i = 0; i < 300; i++) step(0, 1, 3, WIDTH'(i), '0);
    chk("tp3_sat", 64'(drop_count), 64'd255);
    step(0, 0, 0, '0, '0);

    // Streaming through channel 1 with two entries held, across wrap-around
    step(0, 1, 1, 32'hA1, '0);
    step(0, 1, 1, 32'hA2, '0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, WIDTH'(32'hB0 + i), 3'b010);
    chk("tp4_head", 64'(out_instr[WIDTH +: WIDTH]), 64'hB8);
    drain();

    // Reset while pushing loses the word
    for (int i = 0; i < 3; i++) step(0, 1, 0, WIDTH'(32'hC0 + i), '0);
    step(1, 1, 0, 32'h55, '0);
    chk("tp5_valid", 64'(out_valid), 64'd0);
    chk("tp5_count", 64'(drop_count), 64'd0);
    step(0, 1, 0, 32'h77, '0);
    chk("tp5_head", 64'(out_instr[0 +: WIDTH]), 64'h77);
    drain();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 299) == 0), $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 3)), $urandom,
           NUM_PORTS'($urandom_range(0, 7)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
